sap_clk_ctrl: RTL
=================

Name: sap_clk_ctrl

Overview:
- Parametrised clock controller for the SAP CPU.
- Replaces the fixed cascade of divide-by-8 derived clocks with a single-clock-domain clock-enable generator.
- The rate is runtime-selectable as a power of two. The controller also supports single-step (debounced push-button) and halt.
- Sits between the board oscillator and the CPU. The CPU runs on clk and only advances on cycles where tick=1.

Parameters:
- CNT_W, 24, prescaler counter width; maximum tick period is 2^CNT_W clk cycles.
- SEL_W, 5, width of the div_sel input.
- DB_W, 16, debounce counter width; a button level change is accepted after 2^DB_W stable cycles.

Ports:
- clk  input  1  system clock (board oscillator).
- rst  input  1  reset; asynchronous, active-high.
- div_sel  input  SEL_W  run-mode tick period = 2^min(div_sel, CNT_W) clk cycles.
- mode  input  1  0 = free-run, 1 = single-step.
- step_btn  input  1  raw asynchronous push-button, active-high.
- cpu_hlt  input  1  CPU halt request, synchronous to clk.
- tick  output  1  registered one-cycle clock-enable pulse to the CPU.
- running  output  1  1 while in RUN state.
- halted  output  1  1 while in HALTED state.
- clk_mon  output  1  tick-rate monitor for an LED (see Optional Feature).

Behaviour:
- Reset (async, active-high) clears all of the following to 0: tick, running, halted, clk_mon, prescaler count, synchronizer flops, debounce counter, debounced button.
- After reset, state = RUN if mode=0, else STEP_IDLE. running reflects the state from the first edge after reset release.
- States and transitions:
  - RUN: mode=1 -> STEP_IDLE.
  - STEP_IDLE: debounced button rises -> STEP_WAIT_REL (one tick issued); mode=0 -> RUN.
  - STEP_WAIT_REL: debounced button falls -> STEP_IDLE. mode=0 -> RUN, which takes priority over the button.
  - Any state: cpu_hlt=1 -> HALTED. HALTED is sticky; only rst leaves it. cpu_hlt has priority over every other event in the same cycle.
- Prescaler in RUN:
  - Down-counter. When count==0: tick<=1 on the next edge, and count reloads with 2^min(div_sel,CNT_W)-1. Otherwise count decrements.
  - div_sel is sampled only at reload, so mid-period changes take effect on the next period.
  - div_sel=0 -> tick high every cycle. div_sel=k -> exactly one tick per 2^k cycles.
  - div_sel >= CNT_W clamps to period 2^CNT_W (reload value all ones).
  - First tick is asserted on the 1st edge after reset release (count resets to 0).
  - Entering RUN from a step state loads count = full period, so the first tick arrives one full period later.
- Step mode:
  - The prescaler is held at 0.
  - Exactly one tick per accepted button press, asserted 1 cycle after the debounced rise.
  - Holding the button gives no further ticks.
- Debounce:
  - 2-flop synchronizer, then a DB_W-bit counter.
  - The counter increments while sync != debounced value and clears when they are equal.
  - On reaching all ones, debounced value <= sync and the counter clears.
  - Net latency from a clean button edge to the tick is 2 (sync) + 2^DB_W (debounce) + 1 (output register) cycles.
  - Glitches shorter than 2^DB_W cycles are rejected.
- HALTED: tick=0 permanently, halted=1, running=0.
  - A tick already registered in the cycle cpu_hlt is sampled still appears; no tick follows it.
- tick is never high in two consecutive cycles unless RUN with effective div_sel=0.

Optional Feature:
- Macro: SAP_CLK_MON_EN.
- Defined: clk_mon toggles on every tick. This gives a 50%-duty square wave at half the tick rate for LED visualisation of CPU speed. Reset value 0; it freezes while halted.
- Undefined: clk_mon is tied to constant 0 and the toggle flop is not synthesised. All other behaviour is identical.

Test Plan:
- rst pulse, mode=0, div_sel=3 -> tick one cycle wide every 8 clks, first tick at edge 1 after release; running=1.
- RUN with div_sel=2, change div_sel to 4 mid-period -> current period completes at 4 cycles, following periods are 16 cycles.
- DB_W=4, mode=1, step_btn bouncing 5 cycles then high 40 cycles then low -> exactly one tick, 2+16+1 cycles after the stable rise.
- RUN with div_sel=1, assert cpu_hlt for 1 cycle -> halted=1 and no further ticks for 100 cycles, even after toggling mode or step_btn; rst restores RUN.
- Assert rst asynchronously mid-period (between edges) -> tick, count and clk_mon are 0 immediately without waiting for an edge.
- With SAP_CLK_MON_EN, div_sel=2 -> clk_mon period is 8 clks. Without the macro -> clk_mon stays 0.

Source files
------------

// File: rtl/sap_clk_ctrl_if.sv
// sap_clk_ctrl_if: control/status bundle between the board-side logic and the
// SAP clock controller. The master side drives rate, mode, button and halt
// request; the slave (the controller) returns tick and status flags.
interface sap_clk_ctrl_if #(
  parameter int SEL_W = 5
) ();
  logic [SEL_W-1:0] div_sel;
  logic             mode;
  logic             step_btn;
  logic             cpu_hlt;
  logic             tick;
  logic             running;
  logic             halted;
  logic             clk_mon;

  modport master (
    output div_sel, mode, step_btn, cpu_hlt,
    input  tick, running, halted, clk_mon
  );

  modport slave (
    input  div_sel, mode, step_btn, cpu_hlt,
    output tick, running, halted, clk_mon
  );
endinterface

// File: rtl/sap_clk_ctrl.sv
// sap_clk_ctrl: single-clock-domain clock-enable generator for the SAP CPU.
// Free-run mode emits one tick every 2^min(div_sel,CNT_W) cycles; step mode
// emits one tick per debounced button press; cpu_hlt latches a sticky halt.
// Optional macro SAP_CLK_MON_EN adds clk_mon, a toggle-per-tick LED monitor;
// without it clk_mon is tied low.
module sap_clk_ctrl #(
  parameter int CNT_W = 24,
  parameter int SEL_W = 5,
  parameter int DB_W  = 16
) (
  input  logic          clk,
  input  logic          rst,
  sap_clk_ctrl_if.slave bus
);

  // S_INIT only exists for the first edge after reset, so the run/step choice
  // follows the mode input without a mode-dependent async reset value.
  typedef enum logic [2:0] {
    S_INIT,
    S_RUN,
    S_STEP_IDLE,
    S_STEP_WAIT_REL,
    S_HALTED
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic [CNT_W-1:0] reload;
  logic [SEL_W-1:0] div_sel;
  logic             tick_q;
  logic             tick_next;
  logic             running_q;
  logic             halted_q;

  logic             sync1;
  logic             sync2;
  logic             db;
  logic             db_prev;
  logic [DB_W-1:0]  db_cnt;
  logic             db_rise;

  assign div_sel = bus.div_sel;
  assign db_rise = db & ~db_prev;

  // Reload value 2^min(div_sel,CNT_W)-1: low bits set, saturating at all ones.
  always_comb begin
    reload = '0;
    for (int unsigned i = 0; i < CNT_W; i++) begin
      reload[i] = (i < 32'(div_sel));
    end
  end

  // Button synchronizer and debounce counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      db      <= 1'b0;
      db_prev <= 1'b0;
      db_cnt  <= '0;
    end else begin
      sync1   <= bus.step_btn;
      sync2   <= sync1;
      db_prev <= db;
      if (sync2 == db) begin
        db_cnt <= '0;
      end else if (db_cnt == '1) begin
        db     <= sync2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  // Next-state, prescaler and tick decode; cpu_hlt outranks everything.
  always_comb begin
    state_next = state;
    count_next = count;
    tick_next  = 1'b0;
    if (bus.cpu_hlt) begin
      state_next = S_HALTED;
      count_next = '0;
    end else begin
      case (state)
        S_INIT, S_RUN: begin
          if (bus.mode) begin
            state_next = S_STEP_IDLE;
            count_next = '0;
          end else begin
            state_next = S_RUN;
            if (count == '0) begin
              tick_next  = 1'b1;
              count_next = reload;
            end else begin
              count_next = count - CNT_W'(1);
            end
          end
        end
        S_STEP_IDLE: begin
          count_next = '0;
          if (!bus.mode) begin
            state_next = S_RUN;
            count_next = reload;
          end else if (db_rise) begin
            state_next = S_STEP_WAIT_REL;
            tick_next  = 1'b1;
          end
        end
        S_STEP_WAIT_REL: begin
          count_next = '0;
          if (!bus.mode) begin
            state_next = S_RUN;
            count_next = reload;
          end else if (!db) begin
            state_next = S_STEP_IDLE;
          end
        end
        S_HALTED: begin
          count_next = '0;
        end
        default: begin
          state_next = S_INIT;
          count_next = '0;
        end
      endcase
    end
  end

  // State, prescaler and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_INIT;
      count     <= '0;
      tick_q    <= 1'b0;
      running_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state     <= state_next;
      count     <= count_next;
      tick_q    <= tick_next;
      running_q <= (state_next == S_RUN);
      halted_q  <= (state_next == S_HALTED);
    end
  end

  assign bus.tick    = tick_q;
  assign bus.running = running_q;
  assign bus.halted  = halted_q;

`ifdef SAP_CLK_MON_EN
  logic mon_q;

  // Toggle once per issued tick; no ticks while halted, so it freezes there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mon_q <= 1'b0;
    end else begin
      mon_q <= mon_q ^ tick_q;
    end
  end

  assign bus.clk_mon = mon_q;
`else
  assign bus.clk_mon = 1'b0;
`endif

endmodule
